// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: ALU select codes plus the
// multiply/divide engine's operation and state encodings.
package cpu_pkg;

  // ALU selects routed to the multiply/divide engine instead of the ALU
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_DIV = 4'b0011;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine.
// One result bit per cycle; mul and div share the accumulator and shadow regs.
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  muldiv_op_e           op,
  input  logic [WIDTH-1:0]     in0,
  input  logic [WIDTH-1:0]     in1,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     out,
  output logic [WIDTH-1:0]     out_hi,
  output logic                 div_by_zero,
  output muldiv_state_e        o_dbg_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Handshake: start is sampled on a rising edge only in IDLE or DONE; the
  // operands are captured on that same edge. done is a one-cycle pulse with
  // busy low, and the result ports hold until the next completion.
  muldiv_state_e          r_state;
  muldiv_state_e          w_state_nxt;
  muldiv_op_e             r_op;
  logic [CNT_W-1:0]       r_cnt;
  logic [WIDTH-1:0]       r_a;
  logic [2*WIDTH-1:0]     r_acc;
  logic                   w_accept;
  logic                   w_dz;
  logic                   w_last;

  logic [WIDTH-1:0]       w_hi;
  logic [WIDTH-1:0]       w_lo;
  logic [WIDTH:0]         w_sum;
  logic [2*WIDTH-1:0]     w_mul_nxt;
  logic [WIDTH:0]         w_shift;
  logic                   w_ge;
  logic [WIDTH-1:0]       w_diff;
  logic [2*WIDTH-1:0]     w_div_nxt;
  logic [2*WIDTH-1:0]     w_acc_nxt;

  assign o_dbg_state = r_state;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_dz        = 1'b0;
    w_last      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      MD_IDLE, MD_DONE: begin
        done        = (r_state == MD_DONE);
        w_state_nxt = MD_IDLE;
        if (start) begin
          w_accept    = 1'b1;
          // Zero divisor is resolved at accept and skips the iteration phase
          w_dz        = (op == MD_DIV) && (in1 == '0);
          w_state_nxt = w_dz ? MD_DONE : MD_RUN;
        end
      end
      MD_RUN: begin
        busy = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = MD_DONE;
        end
      end
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MD_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Accumulator layout for both ops: {hi, lo}. Multiply keeps the partial
  // product in hi and the unconsumed multiplier in lo; divide keeps the
  // partial remainder in hi and the dividend/quotient in lo.
  assign w_hi = r_acc[2*WIDTH-1:WIDTH];
  assign w_lo = r_acc[WIDTH-1:0];

  assign w_sum     = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_a} : '0);
  assign w_mul_nxt = {w_sum, w_lo[WIDTH-1:1]};

  assign w_shift   = {w_hi, w_lo[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_a});
  // When the trial subtract succeeds the difference is below the divisor,
  // so the low WIDTH bits carry the whole result.
  assign w_diff    = w_shift[WIDTH-1:0] - r_a;
  assign w_div_nxt = {(w_ge ? w_diff : w_shift[WIDTH-1:0]),
                      w_lo[WIDTH-2:0], w_ge};

  assign w_acc_nxt = (r_op == MD_DIV) ? w_div_nxt : w_mul_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= MD_MUL;
      r_cnt       <= '0;
      r_a         <= '0;
      r_acc       <= '0;
      out         <= '0;
      out_hi      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= op;
        r_cnt <= '0;
        r_a   <= (op == MD_DIV) ? in1 : in0;
        r_acc <= {{WIDTH{1'b0}}, ((op == MD_DIV) ? in0 : in1)};
      end else if (r_state == MD_RUN) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_accept && w_dz) begin
        out         <= '1;
        out_hi      <= in0;
        div_by_zero <= 1'b1;
      end else if (w_last) begin
        out         <= w_acc_nxt[WIDTH-1:0];
        out_hi      <= w_acc_nxt[2*WIDTH-1:WIDTH];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed test of muldiv_unit: latency, results, divide-by-zero,
// ignored start while busy, back-to-back issue and mid-operation reset.
module tb_muldiv_unit;
  import cpu_pkg::*;

  localparam int W = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  muldiv_op_e    op;
  logic [W-1:0]  in0;
  logic [W-1:0]  in1;
  logic          busy;
  logic          done;
  logic [W-1:0]  out;
  logic [W-1:0]  out_hi;
  logic          div_by_zero;
  muldiv_state_e dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .in0         (in0),
    .in1         (in1),
    .busy        (busy),
    .done        (done),
    .out         (out),
    .out_hi      (out_hi),
    .div_by_zero (div_by_zero),
    .o_dbg_state (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge: present a request, let one rising edge accept it,
  // return at the following negedge with start low and operands scrambled.
  task automatic issue(input muldiv_op_e o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    in0   = a;
    in1   = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    in0   = W'($urandom_range(0, 65535));
    in1   = W'($urandom_range(0, 65535));
    op    = ($urandom_range(0, 1) == 1) ? MD_DIV : MD_MUL;
  endtask

  // Counts rising edges after the accept edge until done is seen (bounded).
  // Optionally pulses start with junk operands at one point of the run.
  task automatic wait_done(input string tag, input int exp_lat, input int glitch_at);
    int lat;
    int busy_n;
    lat    = 0;
    busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      if (lat == glitch_at) begin
        start = 1'b1;
        op    = MD_MUL;
        in0   = 16'd99;
        in1   = 16'd99;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] lo,
                           input logic [W-1:0] hi, input logic dz);
    check({tag, "_out"}, 32'(out), 32'(lo));
    check({tag, "_out_hi"}, 32'(out_hi), 32'(hi));
    check({tag, "_dz"}, 32'(div_by_zero), 32'(dz));
  endtask

  // After a non-chained completion the pulse must end and the FSM go idle.
  task automatic check_drop(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(dbg_state), 32'(MD_IDLE));
  endtask

  task automatic run_op(input string tag, input muldiv_op_e o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] lo,
                        input logic [W-1:0] hi, input logic dz, input int lat);
    issue(o, a, b);
    wait_done(tag, lat, -1);
    check_res(tag, lo, hi, dz);
    check_drop(tag);
  endtask

  initial begin
    int saw_done;
    rst_n = 1'b0;
    start = 1'b0;
    op    = MD_MUL;
    in0   = '0;
    in1   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_res("rst", 16'h0000, 16'h0000, 1'b0);
    check("rst_state", 32'(dbg_state), 32'(MD_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul_13x6", MD_MUL, 16'd13, 16'd6, 16'd78, 16'd0, 1'b0, 16);
    run_op("mul_ffff", MD_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 16);
    run_op("mul_1000sq", MD_MUL, 16'd1000, 16'd1000, 16'h4240, 16'h000F, 1'b0, 16);
    run_op("div_13_6", MD_DIV, 16'd13, 16'd6, 16'd2, 16'd1, 1'b0, 16);
    run_op("div_6_13", MD_DIV, 16'd6, 16'd13, 16'd0, 16'd6, 1'b0, 16);
    run_op("div_ffff_1", MD_DIV, 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 16);
    run_op("div_by_0", MD_DIV, 16'd100, 16'd0, 16'hFFFF, 16'd100, 1'b1, 0);
    run_op("mul_7x3", MD_MUL, 16'd7, 16'd3, 16'd21, 16'd0, 1'b0, 16);

    // start pulsed mid-run is ignored
    issue(MD_MUL, 16'd13, 16'd6);
    wait_done("mul_glitch", 16, 5);
    check_res("mul_glitch", 16'd78, 16'd0, 1'b0);
    check_drop("mul_glitch");

    // back-to-back: issue the next op in the DONE cycle
    issue(MD_MUL, 16'd300, 16'd200);
    wait_done("b2b_first", 16, -1);
    check_res("b2b_first", 16'hEA60, 16'd0, 1'b0);
    issue(MD_DIV, 16'd50000, 16'd123);
    check("b2b_done_drops", 32'(done), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done("b2b_second", 16, -1);
    check_res("b2b_second", 16'd406, 16'd62, 1'b0);
    check_drop("b2b_second");

    // reset mid-divide aborts immediately with no done pulse
    issue(MD_DIV, 16'd50000, 16'd7);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check_res("abort", 16'd0, 16'd0, 1'b0);
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    run_op("div_200_7", MD_DIV, 16'd200, 16'd7, 16'd28, 16'd4, 1'b0, 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
